// File: rtl/piso_deb_pkg.sv
// -----------------------------------------------------------------------------
// piso_deb_pkg
// Shared definitions for the piso_deb_stream slice.
//   - DEF_DW / DEF_NWORDS : default beat width and beats per frame
//   - state_t             : serialiser FSM states
// -----------------------------------------------------------------------------
package piso_deb_pkg;

  localparam int DEF_DW     = 8;
  localparam int DEF_NWORDS = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CSUM = 2'd2
  } state_t;

endpackage

// File: rtl/piso_deb_stream_if.sv
// -----------------------------------------------------------------------------
// piso_deb_stream_if
// Control and stream signals of the parallel-in / serial-out streamer.
//   Control : EN_PISO_DEB, CLR_PISO_DEB, START, D_IN (NWORDS*DW frame)
//   Stream  : D_OUT, VALID, LAST, READY
//   Status  : BUSY, DONE, OVR
// modport slave  : the streamer (consumes control, drives stream/status)
// modport master : the controller / sink side
// -----------------------------------------------------------------------------
interface piso_deb_stream_if
  import piso_deb_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int NWORDS = DEF_NWORDS
);

  logic                 EN_PISO_DEB;
  logic                 CLR_PISO_DEB;
  logic                 START;
  logic [NWORDS*DW-1:0] D_IN;
  logic                 READY;
  logic [DW-1:0]        D_OUT;
  logic                 VALID;
  logic                 LAST;
  logic                 BUSY;
  logic                 DONE;
  logic                 OVR;

  modport master (
    output EN_PISO_DEB, CLR_PISO_DEB, START, D_IN, READY,
    input  D_OUT, VALID, LAST, BUSY, DONE, OVR
  );

  modport slave (
    input  EN_PISO_DEB, CLR_PISO_DEB, START, D_IN, READY,
    output D_OUT, VALID, LAST, BUSY, DONE, OVR
  );

endinterface

// File: rtl/piso_deb_csum.sv
// -----------------------------------------------------------------------------
// piso_deb_csum
// Combinational XOR reduction of all NWORDS beats of a frame.
//   i_frame : NWORDS*DW frame (beat order is irrelevant to XOR)
//   o_csum  : DW-bit XOR of every beat
// -----------------------------------------------------------------------------
module piso_deb_csum
  import piso_deb_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int NWORDS = DEF_NWORDS
) (
  input  logic [NWORDS*DW-1:0] i_frame,
  output logic [DW-1:0]        o_csum
);

  always_comb begin
    o_csum = '0;
    for (int i = 0; i < NWORDS; i++) begin
      o_csum = o_csum ^ i_frame[i*DW +: DW];
    end
  end

endmodule

// File: rtl/piso_deb_stream.sv
// -----------------------------------------------------------------------------
// piso_deb_stream
// Snapshots a NWORDS*DW frame on START and streams it MSB-beat-first over a
// VALID/READY handshake, optionally followed by an XOR checksum beat.
//   CLKEXT  : clock (rising edge)
//   RST_GLO : asynchronous active-high reset
//   bus     : piso_deb_stream_if.slave (control, stream and status signals)
// -----------------------------------------------------------------------------
module piso_deb_stream
  import piso_deb_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int NWORDS  = DEF_NWORDS,
  parameter int CSUM_EN = 0
) (
  input  logic             CLKEXT,
  input  logic             RST_GLO,
  piso_deb_stream_if.slave bus
);

  localparam int            FW       = NWORDS * DW;
  localparam int            CW       = $clog2(NWORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);
  localparam bit            HAS_CSUM = (CSUM_EN != 0);

  state_t        r_state;
  state_t        w_state_next;
  logic [FW-1:0] r_shift;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_csum;
  logic          r_done;
  logic          r_ovr;

  logic [DW-1:0] w_csum;
  logic [DW-1:0] w_dout;
  logic          w_valid;
  logic          w_last;
  logic          w_start_ok;
  logic          w_xfer;
  logic          w_final_data;

  // Checksum is taken from D_IN at snapshot time; the shift register loses
  // the early beats as it shifts, so it cannot be recomputed later.
  piso_deb_csum #(
    .DW     (DW),
    .NWORDS (NWORDS)
  ) u_csum (
    .i_frame (bus.D_IN),
    .o_csum  (w_csum)
  );

  assign w_start_ok   = bus.START & bus.EN_PISO_DEB & ~bus.CLR_PISO_DEB;
  assign w_final_data = (r_state == ST_SEND) && (r_cnt == LAST_IDX);
  assign w_xfer       = w_valid & bus.READY;

  // State register
  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; clear overrides everything, including transfers
  always_comb begin
    w_state_next = r_state;
    if (bus.CLR_PISO_DEB) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start_ok) w_state_next = ST_SEND;
        ST_SEND: if (w_xfer && w_final_data) w_state_next = HAS_CSUM ? ST_CSUM : ST_IDLE;
        ST_CSUM: if (w_xfer) w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Output logic, decoded from registered state only
  always_comb begin
    w_valid = (r_state != ST_IDLE);
    w_last  = (r_state == ST_CSUM) || (w_final_data && !HAS_CSUM);
    w_dout  = (r_state == ST_CSUM) ? r_csum : r_shift[FW-1 -: DW];
  end

  // Datapath: shift register, beat counter, checksum, status flags
  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_csum  <= '0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (bus.CLR_PISO_DEB) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_csum  <= '0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_done <= w_xfer & w_last;
      if ((r_state == ST_IDLE) && w_start_ok) begin
        r_shift <= bus.D_IN;
        r_cnt   <= '0;
        r_csum  <= w_csum;
      end else if ((r_state == ST_SEND) && w_xfer) begin
        r_shift <= {r_shift[FW-DW-1:0], {DW{1'b0}}};
        // Explicit wrap so non-power-of-two NWORDS restart at beat 0
        r_cnt   <= w_final_data ? '0 : r_cnt + CW'(1);
      end
      if (w_start_ok && w_valid) begin
        r_ovr <= 1'b1;
      end
    end
  end

  assign bus.D_OUT = w_dout;
  assign bus.VALID = w_valid;
  assign bus.LAST  = w_last;
  assign bus.BUSY  = w_valid;
  assign bus.DONE  = r_done;
  assign bus.OVR   = r_ovr;

endmodule

// File: tb/tb_piso_deb_stream.sv
// -----------------------------------------------------------------------------
// tb_piso_deb_stream
// Three streamer instances: (DW=8,NWORDS=12,CSUM_EN=0), (8,12,1), (16,4,1).
// A frame-level model (queue of expected beats per instance) is compared with
// the DUT outputs on every falling edge; directed frames pin the model with
// literal beat values, checksums and DONE timing.
// -----------------------------------------------------------------------------
module tb_piso_deb_stream;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0] en    = '1;
  logic [NI-1:0] clr   = '0;
  logic [NI-1:0] start = '0;
  logic [NI-1:0] ready = '1;
  logic [95:0]   din [NI];

  logic [15:0]   dout [NI];
  logic [NI-1:0] valid, last, busy, done, ovr;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int GDW = (gi == 2) ? 16 : 8;
    localparam int GNW = (gi == 2) ? 4 : 12;
    localparam int GCS = (gi == 0) ? 0 : 1;

    piso_deb_stream_if #(.DW(GDW), .NWORDS(GNW)) ifc ();

    assign ifc.EN_PISO_DEB  = en[gi];
    assign ifc.CLR_PISO_DEB = clr[gi];
    assign ifc.START        = start[gi];
    assign ifc.READY        = ready[gi];
    assign ifc.D_IN         = din[gi][GNW*GDW-1:0];
    assign dout[gi]         = 16'(ifc.D_OUT);
    assign valid[gi]        = ifc.VALID;
    assign last[gi]         = ifc.LAST;
    assign busy[gi]         = ifc.BUSY;
    assign done[gi]         = ifc.DONE;
    assign ovr[gi]          = ifc.OVR;

    piso_deb_stream #(.DW(GDW), .NWORDS(GNW), .CSUM_EN(GCS)) u_dut (
      .CLKEXT  (clk),
      .RST_GLO (rst),
      .bus     (ifc)
    );
  end

  function automatic int dw_of(int k); return (k == 2) ? 16 : 8; endfunction
  function automatic int nw_of(int k); return (k == 2) ? 4 : 12; endfunction
  function automatic int cs_of(int k); return (k == 0) ? 0 : 1; endfunction

  // ---------------- model: queue of {last, beat} per instance ----------------
  logic [16:0] mq [NI][16];
  int          mh [NI];
  int          mt [NI];
  logic        mdone [NI];
  logic        movr  [NI];

  // ---------------- capture of accepted beats ----------------
  logic [16:0] cap [NI][64];
  int          caplen   [NI];
  int          done_cyc [NI];
  int          lx_cyc   [NI];
  int          cyc_n = 0;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp35 [12] = '{8'hAA, 8'hAA, 8'h55, 8'h55, 8'h12, 8'h34,
                             8'hAB, 8'hCD, 8'h01, 8'h02, 8'h03, 8'h04};
  localparam logic [95:0] D35 = 96'hAAAA_5555_1234_ABCD_0102_0304;
  localparam logic [95:0] D36 = 96'hFFFF_0000_DEAD_BEEF_AABB_CCDD;
  localparam logic [95:0] D40 = 96'h0001_0002_0004_8000;

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  task automatic model_load(int k);
    int          dw, nw, cs;
    logic [15:0] b, acc;
    logic [95:0] mask;
    dw   = dw_of(k);
    nw   = nw_of(k);
    cs   = cs_of(k);
    mask = (dw == 16) ? 96'hFFFF : 96'hFF;
    acc  = '0;
    mh[k] = 0;
    mt[k] = 0;
    for (int i = 0; i < nw; i++) begin
      b   = 16'((din[k] >> ((nw - 1 - i) * dw)) & mask);
      acc = acc ^ b;
      mq[k][mt[k]] = {(i == nw - 1) && (cs == 0), b};
      mt[k]++;
    end
    if (cs != 0) begin
      mq[k][mt[k]] = {1'b1, acc};
      mt[k]++;
    end
  endtask

  task automatic model_step(int k);
    logic was_busy;
    was_busy = (mt[k] > mh[k]);
    if (clr[k]) begin
      mh[k] = 0; mt[k] = 0; mdone[k] = 1'b0; movr[k] = 1'b0;
    end else begin
      mdone[k] = 1'b0;
      if (was_busy && ready[k]) begin
        mh[k]++;
        if (mh[k] == mt[k]) mdone[k] = 1'b1;
      end
      if (start[k] && en[k]) begin
        if (!was_busy) model_load(k);
        else           movr[k] = 1'b1;
      end
    end
  endtask

  // Model update at each clock edge / asynchronous reset
  initial begin
    for (int k = 0; k < NI; k++) begin
      mh[k] = 0; mt[k] = 0; mdone[k] = 1'b0; movr[k] = 1'b0;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < NI; k++) begin
        if (rst) begin
          mh[k] = 0; mt[k] = 0; mdone[k] = 1'b0; movr[k] = 1'b0;
        end else begin
          model_step(k);
        end
      end
    end
  end

  // Compare process: every falling edge, outside reset
  initial begin
    logic        ev;
    logic [16:0] eb;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (!rst) begin
        for (int k = 0; k < NI; k++) begin
          ev = (mt[k] > mh[k]);
          eb = ev ? mq[k][mh[k]] : 17'h0;
          chk("valid", k, 32'(valid[k]), 32'(ev));
          chk("busy",  k, 32'(busy[k]),  32'(ev));
          chk("last",  k, 32'(last[k]),  32'(eb[16]));
          chk("done",  k, 32'(done[k]),  32'(mdone[k]));
          chk("ovr",   k, 32'(ovr[k]),   32'(movr[k]));
          if (ev) chk("dout", k, 32'(dout[k]), 32'(eb[15:0]));
          if (valid[k] && ready[k] && caplen[k] < 64) begin
            cap[k][caplen[k]] = {last[k], dout[k]};
            caplen[k]++;
            if (last[k]) lx_cyc[k] = cyc_n;
          end
          if (done[k]) done_cyc[k] = cyc_n;
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_caps();
    for (int k = 0; k < NI; k++) begin
      caplen[k] = 0; done_cyc[k] = -1; lx_cyc[k] = -1;
    end
  endtask

  task automatic wait_idle(int k);
    int t;
    t = 0;
    while (busy[k] && t < 200) begin
      cyc(1);
      t++;
    end
    chk("idle_timeout", k, 32'(busy[k]), 32'h0);
    cyc(2);
  endtask

  task automatic check_zero(string nm);
    for (int k = 0; k < NI; k++) begin
      chk({nm, "_dout"},  k, 32'(dout[k]),  32'h0);
      chk({nm, "_valid"}, k, 32'(valid[k]), 32'h0);
      chk({nm, "_last"},  k, 32'(last[k]),  32'h0);
      chk({nm, "_busy"},  k, 32'(busy[k]),  32'h0);
      chk({nm, "_done"},  k, 32'(done[k]),  32'h0);
      chk({nm, "_ovr"},   k, 32'(ovr[k]),   32'h0);
    end
  endtask

  task automatic check_frame35(string nm);
    chk({nm, "_len"}, 0, 32'(caplen[0]), 32'd12);
    for (int i = 0; i < 12; i++) chk(nm, 0, 32'(cap[0][i][7:0]), 32'(exp35[i]));
    chk({nm, "_last_on_04"}, 0, 32'(cap[0][11][16]), 32'h1);
  endtask

  initial begin
    int t;
    logic [3:0] rpat;
    rpat = 4'b1001;
    for (int k = 0; k < NI; k++) din[k] = '0;
    clear_caps();

    // Reset state
    cyc(3);
    check_zero("reset");
    rst = 1'b0;
    cyc(2);

    // Literal frames on all three instances; D_IN scrambled after snapshot
    din[0] = D35; din[1] = D35; din[2] = D40;
    clear_caps();
    start = '1; cyc(1); start = '0;
    for (int k = 0; k < NI; k++) din[k] = {$urandom, $urandom, $urandom};
    for (int k = 0; k < NI; k++) wait_idle(k);
    check_frame35("frame35");
    chk("frame35_not_last", 0, 32'(cap[0][10][16]), 32'h0);
    chk("frame35_done_t", 0, 32'(done_cyc[0]), 32'(lx_cyc[0] + 1));
    chk("csum35_len", 1, 32'(caplen[1]), 32'd13);
    chk("csum35", 1, 32'(cap[1][12]), 32'h1_0044);
    chk("csum35_d11_nolast", 1, 32'(cap[1][11][16]), 32'h0);
    chk("w16_len", 2, 32'(caplen[2]), 32'd5);
    chk("w16_beat0", 2, 32'(cap[2][0]), 32'h0_0001);
    chk("w16_csum", 2, 32'(cap[2][4]), 32'h1_8007);
    chk("w16_done_t", 2, 32'(done_cyc[2]), 32'(lx_cyc[2] + 1));

    // Second checksum literal
    din[1] = D36;
    clear_caps();
    start[1] = 1'b1; cyc(1); start[1] = 1'b0;
    wait_idle(1);
    chk("csum36", 1, 32'(cap[1][12]), 32'h1_0022);
    chk("csum36_beat4", 1, 32'(cap[1][4][7:0]), 32'hDE);

    // READY pattern 1,0,0,1 with EN dropped mid-frame
    din[0] = D35;
    clear_caps();
    start[0] = 1'b1; cyc(1); start[0] = 1'b0;
    en[0] = 1'b0;
    t = 0;
    while (busy[0] && t < 200) begin
      ready[0] = rpat[t % 4];
      cyc(1);
      t++;
    end
    ready[0] = 1'b1; en[0] = 1'b1;
    wait_idle(0);
    check_frame35("ready_toggle");

    // START while busy sets OVR, frame unchanged; CLR clears OVR
    clear_caps();
    start[0] = 1'b1; cyc(1); start[0] = 1'b0;
    cyc(4);
    din[0] = {$urandom, $urandom, $urandom};
    start[0] = 1'b1; cyc(1); start[0] = 1'b0;
    wait_idle(0);
    check_frame35("ovr_frame");
    chk("ovr_sticky", 0, 32'(ovr[0]), 32'h1);
    clr[0] = 1'b1; cyc(1); clr[0] = 1'b0;
    chk("ovr_cleared", 0, 32'(ovr[0]), 32'h0);

    // Asynchronous reset in the middle of beat 7
    din[0] = D35; din[1] = D35; din[2] = D40;
    start = '1; cyc(1); start = '0;
    cyc(7);
    clear_caps();
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    cyc(1);
    rst = 1'b0;
    cyc(2);
    chk("rst_no_done", 0, 32'(done_cyc[0]), 32'hFFFF_FFFF);
    start = '1; cyc(1); start = '0;
    for (int k = 0; k < NI; k++) wait_idle(k);
    check_frame35("after_rst");

    // CLR mid-frame: abort, no DONE
    clear_caps();
    start[1] = 1'b1; start[2] = 1'b1; cyc(1); start = '0;
    cyc(2);
    clr[1] = 1'b1; clr[2] = 1'b1; cyc(1); clr = '0;
    chk("clr_abort_busy", 1, 32'(busy[1]), 32'h0);
    cyc(2);
    chk("clr_no_done", 2, 32'(done_cyc[2]), 32'hFFFF_FFFF);

    // Back-to-back: new START in the DONE cycle
    din[2] = {$urandom, $urandom, $urandom};
    start[2] = 1'b1; cyc(1); start[2] = 1'b0;
    t = 0;
    while (!done[2] && t < 50) begin
      cyc(1);
      t++;
    end
    chk("b2b_done_seen", 2, 32'(done[2]), 32'h1);
    din[2] = {$urandom, $urandom, $urandom};
    start[2] = 1'b1; cyc(1); start[2] = 1'b0;
    chk("b2b_restart", 2, 32'(busy[2]), 32'h1);
    wait_idle(2);

    // Randomised traffic checked against the model every cycle
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NI; k++) begin
        en[k]    = ($urandom_range(0, 9) != 0);
        clr[k]   = ($urandom_range(0, 59) == 0);
        start[k] = ($urandom_range(0, 7) == 0);
        ready[k] = ($urandom_range(0, 9) < 7);
        din[k]   = {$urandom, $urandom, $urandom};
      end
      cyc(1);
    end
    en = '1; clr = '0; start = '0; ready = '1;
    for (int k = 0; k < NI; k++) wait_idle(k);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/piso_deb_stream.md
PISO_DEB_STREAM -- requirements
Module: piso_deb_stream

Interface
REQ-001 Parameter DW, default 8: width of one output beat in bits.
REQ-002 Parameter NWORDS, default 12: beats per frame, legal range 2..256.
REQ-003 Parameter CSUM_EN, default 0: 1 appends one XOR-checksum beat after the data beats.
REQ-004 CLKEXT  input  1  single clock; all state updates on its rising edge.
REQ-005 RST_GLO  input  1  reset, asynchronous, active-high.
REQ-006 EN_PISO_DEB  input  1  block enable; START is ignored while low.
REQ-007 CLR_PISO_DEB  input  1  synchronous clear / abort.
REQ-008 START  input  1  single-cycle request to snapshot D_IN and send a frame.
REQ-009 D_IN  input  NWORDS*DW  parallel frame; beat 0 = D_IN[NWORDS*DW-1 -: DW], MSB-first.
REQ-010 READY  input  1  sink accepts the current beat.
REQ-011 D_OUT  output  DW  current beat.
REQ-012 VALID  output  1  D_OUT holds a beat.
REQ-013 LAST  output  1  marks the final beat of the frame.
REQ-014 BUSY  output  1  frame in progress (VALID included).
REQ-015 DONE  output  1  one-cycle pulse after the final beat is accepted.
REQ-016 OVR  output  1  sticky flag: START arrived while BUSY.

Function
REQ-017 FSM states: IDLE, SEND, CSUM; beat counter width $clog2(NWORDS).
REQ-018 IDLE with START=1, EN_PISO_DEB=1, CLR_PISO_DEB=0: snapshot D_IN into the shift register, counter=0, go to SEND.
REQ-019 First beat latency: VALID=1 and D_OUT=beat 0 in the cycle after START is sampled.
REQ-020 A beat is transferred only when VALID&&READY; while READY=0, D_OUT, LAST and the counter hold.
REQ-021 Each transfer in SEND shifts the register by DW bits toward the MSB and increments the counter.
REQ-022 When beat NWORDS-1 transfers: go to CSUM if CSUM_EN=1, otherwise go to IDLE with VALID=0.
REQ-023 CSUM state: D_OUT = XOR of all NWORDS snapshot beats, VALID=1; on transfer go to IDLE.
REQ-024 LAST=1 only on the final beat: beat NWORDS-1 when CSUM_EN=0, the checksum beat when CSUM_EN=1.
REQ-025 DONE pulses high for exactly one cycle, in the cycle after the final transfer.
REQ-026 START while BUSY is ignored and sets OVR; the frame in progress is unaffected.
REQ-027 CLR_PISO_DEB=1 has priority over START and over transfers:
  - state goes to IDLE;
  - VALID, LAST, BUSY, DONE, OVR, counter and shift register are cleared next cycle;
  - no DONE is issued for the aborted frame.
REQ-028 EN_PISO_DEB going low mid-frame does not stall or abort the frame.
REQ-029 Changes on D_IN after the snapshot do not affect the frame in progress.
REQ-030 A new START may be accepted in the same cycle DONE is high; the state is then IDLE.

Reset
REQ-031 RST_GLO=1 forces IDLE asynchronously:
  - D_OUT=0, VALID=0, LAST=0, BUSY=0, DONE=0, OVR=0;
  - counter=0, shift register=0, checksum=0.
REQ-032 Reset mid-frame discards the frame with no DONE; normal operation resumes on the first edge after deassertion.

Structure
REQ-033 Shared package piso_deb_pkg holds the FSM state enum and the default DW/NWORDS values.
REQ-034 The checksum accumulator is a sub-module, piso_deb_csum (combinational XOR reduce over the snapshot, parametrised by DW and NWORDS).

Verification
REQ-035 Defaults, CSUM_EN=0, READY=1, D_IN=AAAA_5555_1234_ABCD_01_02_03_04, START pulse:
  - D_OUT = AA,AA,55,55,12,34,AB,CD,01,02,03,04 on 12 consecutive cycles;
  - LAST on 04; DONE one cycle later.
REQ-036 CSUM_EN=1, D_IN=FFFF_0000_DEAD_BEEF_AA_BB_CC_DD:
  - 12 data beats, then checksum beat 22 with LAST=1.
  - With the REQ-035 data, the checksum beat is 44.
REQ-037 READY toggled 1,0,0,1 per cycle during a frame: D_OUT holds during READY=0; no beat is duplicated or lost; total 12 transfers.
REQ-038 Second START at beat 5: frame completes unchanged and OVR=1 stays set; CLR_PISO_DEB then clears OVR.
REQ-039 RST_GLO asserted mid-beat 7 (asynchronous, between edges): all outputs 0 immediately; no DONE; next START sends a full frame from beat 0.
REQ-040 Parameter sweep DW=16, NWORDS=4, CSUM_EN=1: 5 beats; checksum equals the XOR of the 4 words; counter wraps cleanly between back-to-back frames.
